// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing generator with frame-aligned pattern scheduling
// Optional feature macro: RGB_PATTERN_AUTOCYCLE_EN (advance the pattern every FRAMES_PER_PATTERN frames)
module video_timing_ctrl #(
    parameter int H_ACTIVE           = 800,
    parameter int H_FP               = 40,
    parameter int H_SYNC             = 128,
    parameter int H_BP               = 88,
    parameter int V_ACTIVE           = 600,
    parameter int V_FP               = 1,
    parameter int V_SYNC             = 4,
    parameter int V_BP               = 23,
    parameter bit SYNC_POL           = 1'b1,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [2:0]  i_pattern_sel,
    input  logic        i_pattern_load,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank,
    output logic [10:0] o_pos_x,
    output logic [10:0] o_pos_y,
    output logic        o_frame_start,
    output logic [2:0]  o_pattern_idx,
    output logic        o_running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LST  = 11'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [2:0]  shadow_q, shadow_d;
    logic        load_pend_q, load_pend_d;
    logic [2:0]  pattern_q, pattern_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic [10:0] pos_x_q, pos_x_d;
    logic [10:0] pos_y_q, pos_y_d;
    logic        frame_start_q, frame_start_d;
    logic        running_q, running_d;

    logic counting;
    logic h_last;
    logic v_last;
    logic frame_last;
    logic frame_first;
    logic active;
    logic hs_on;
    logic vs_on;

    assign counting    = (state_q != IDLE);
    assign h_last      = (h_cnt_q == H_LST);
    assign v_last      = (v_cnt_q == V_LST);
    assign frame_last  = counting && h_last && v_last;
    assign frame_first = counting && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_on       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_on       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    // Enable is re-sampled every cycle, so dropping it only matters if it is still low at the last pixel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_enable) state_d = RUN;
            end
            RUN, STOP_PEND: begin
                if (i_enable)        state_d = RUN;
                else if (frame_last) state_d = IDLE;
                else                 state_d = STOP_PEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (counting) begin
            h_cnt_d = h_last ? 11'd0 : h_cnt_q + 11'd1;
            v_cnt_d = v_cnt_q;
            if (h_last) v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        blank_d       = 1'b1;
        pos_x_d       = '0;
        pos_y_d       = '0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (counting) begin
            hsync_d       = hs_on ? SYNC_POL : ~SYNC_POL;
            vsync_d       = vs_on ? SYNC_POL : ~SYNC_POL;
            blank_d       = ~active;
            pos_x_d       = active ? h_cnt_q : 11'd0;
            pos_y_d       = active ? v_cnt_q : 11'd0;
            frame_start_d = frame_first;
            running_d     = 1'b1;
        end
    end

`ifdef RGB_PATTERN_AUTOCYCLE_EN
    localparam int FCNT_W = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [FCNT_W-1:0] FPP_W = FCNT_W'(FRAMES_PER_PATTERN);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Counts completed frames; cleared whenever the pattern changes at a frame start.
    always_comb begin
        fcnt_d = fcnt_q;
        if (!counting) begin
            fcnt_d = '0;
        end else if (frame_first && (load_pend_q || (fcnt_q == FPP_W))) begin
            fcnt_d = '0;
        end else if (frame_last) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) fcnt_q <= '0;
        else          fcnt_q <= fcnt_d;
    end
`else
    logic unused_fpp;
    assign unused_fpp = ^FRAMES_PER_PATTERN;
`endif

    // The pending flag is tested before this cycle's load, so a load coinciding with a frame start waits a frame.
    always_comb begin
        shadow_d    = shadow_q;
        load_pend_d = load_pend_q;
        pattern_d   = pattern_q;
        if (frame_first && load_pend_q) begin
            pattern_d   = shadow_q;
            load_pend_d = 1'b0;
        end
`ifdef RGB_PATTERN_AUTOCYCLE_EN
        else if (frame_first && (fcnt_q == FPP_W)) begin
            pattern_d = pattern_q + 3'd1;
        end
`endif
        if (i_pattern_load) begin
            shadow_d    = i_pattern_sel;
            load_pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            shadow_q      <= '0;
            load_pend_q   <= 1'b0;
            pattern_q     <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            blank_q       <= 1'b1;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            shadow_q      <= shadow_d;
            load_pend_q   <= load_pend_d;
            pattern_q     <= pattern_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_blank       = blank_q;
    assign o_pos_x       = pos_x_q;
    assign o_pos_y       = pos_y_q;
    assign o_frame_start = frame_start_q;
    assign o_pattern_idx = pattern_q;
    assign o_running     = running_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - self-checking bench for video_timing_ctrl on a reduced raster
module tb_video_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int FPP = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        o_hsync, o_vsync, o_blank, o_frame_start, o_running;
    logic [10:0] o_pos_x, o_pos_y;
    logic [2:0]  o_pattern_idx;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .FRAMES_PER_PATTERN(FPP)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
        .i_pattern_sel(sel), .i_pattern_load(ld),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank),
        .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .o_frame_start(o_frame_start),
        .o_pattern_idx(o_pattern_idx), .o_running(o_running)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit en; bit ld; int sel; int n;
        bit blank; bit hs; bit vs; bit fs; bit run; int x; int y; int idx; bit chk_idx;
    } vec_t;
    vec_t tbl[$];

    // reference model state: frame-relative pixel index and pattern bookkeeping
    bit m_run, m_pend;
    int m_t, m_shadow, m_idx, m_done;
    bit e_blank, e_hs, e_vs, e_fs, e_run;
    int e_x, e_y, e_idx;

    task automatic add(input bit a_en, a_ld, input int a_sel, a_n,
                       input bit b, h, v, f, r, input int x, y, i, input bit c);
        vec_t t;
        t.en = a_en; t.ld = a_ld; t.sel = a_sel; t.n = a_n;
        t.blank = b; t.hs = h; t.vs = v; t.fs = f; t.run = r;
        t.x = x; t.y = y; t.idx = i; t.chk_idx = c;
        tbl.push_back(t);
    endtask

    task automatic step(input bit s_en, s_ld, input int s_sel);
        en = s_en; ld = s_ld; sel = 3'(s_sel);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        en = 1'b0; ld = 1'b0; sel = 3'd0; rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag, input bit b, h, v, f, r,
                             input int x, y, i, input bit c);
        n_vec++;
        if (o_blank !== b || o_hsync !== h || o_vsync !== v || o_frame_start !== f ||
            o_running !== r || o_pos_x !== 11'(x) || o_pos_y !== 11'(y) ||
            (c && o_pattern_idx !== 3'(i))) begin
            n_bad++;
            $display("FAIL %s: got blank=%b hs=%b vs=%b fs=%b run=%b x=%0d y=%0d idx=%0d, want blank=%b hs=%b vs=%b fs=%b run=%b x=%0d y=%0d idx=%0d(chk=%b)",
                     tag, o_blank, o_hsync, o_vsync, o_frame_start, o_running, o_pos_x, o_pos_y,
                     o_pattern_idx, b, h, v, f, r, x, y, i, c);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_t = 0; m_shadow = 0; m_idx = 0; m_done = 0;
    endtask

    // Predicts the outputs visible after the coming clock edge, then advances the model.
    task automatic model_step(input bit s_en, s_ld, input int s_sel);
        int h, v;
        h = m_t % HT;
        v = m_t / HT;
        e_run = m_run;
        e_blank = 1; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0;
        if (m_run) begin
            e_blank = !(h < HA && v < VA);
            e_hs = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs = (v >= VA + VF) && (v < VA + VF + VS);
            e_x = e_blank ? 0 : h;
            e_y = e_blank ? 0 : v;
            e_fs = (m_t == 0);
            if (m_t == 0) begin
                if (m_pend) begin
                    m_idx = m_shadow; m_pend = 0; m_done = 0;
                end
`ifdef RGB_PATTERN_AUTOCYCLE_EN
                else if (m_done >= FPP) begin
                    m_idx = (m_idx + 1) % 8; m_done = 0;
                end
`endif
            end
        end
        if (s_ld) begin
            m_shadow = s_sel; m_pend = 1;
        end
        e_idx = m_idx;
        if (!m_run) begin
            m_run = s_en; m_t = 0; m_done = 0;
        end else if (m_t == FT - 1) begin
            m_t = 0; m_done++;
            if (!s_en) m_run = 0;
        end else begin
            m_t++;
        end
    endtask

    initial begin
        int e, nf, guard;
        bit got;
        int exp_seq[6];
        bit ren, rld;
        int rsel;

        // en ld sel n | blank hs vs fs run x y idx chk   (pixel shown = edges since enable - 2)
        add(1,0,0,1,    1,0,0,0,0, 0,0,0,1);
        add(1,0,0,1,    0,0,0,1,1, 0,0,0,1);
        add(1,0,0,7,    0,0,0,0,1, 7,0,0,1);
        add(1,0,0,1,    1,0,0,0,1, 0,0,0,1);
        add(1,0,0,2,    1,1,0,0,1, 0,0,0,1);
        add(1,0,0,2,    1,1,0,0,1, 0,0,0,1);
        add(1,0,0,1,    1,0,0,0,1, 0,0,0,1);
        add(1,0,0,2,    0,0,0,0,1, 0,1,0,1);
        add(1,1,5,1,    0,0,0,0,1, 1,1,0,1);
        add(1,0,0,48,   0,0,0,0,1, 4,4,0,1);
        add(1,0,0,26,   1,0,1,0,1, 0,0,0,1);
        add(1,0,0,10,   1,1,1,0,1, 0,0,0,1);
        add(1,0,0,19,   1,0,1,0,1, 0,0,0,1);
        add(1,0,0,1,    1,0,0,0,1, 0,0,0,1);
        add(1,0,0,14,   1,0,0,0,1, 0,0,0,1);
        add(1,0,0,1,    0,0,0,1,1, 0,0,5,1);
        add(0,0,0,1,    0,0,0,0,1, 1,0,5,1);
        add(0,0,0,133,  1,0,0,0,1, 0,0,5,1);
        add(0,0,0,1,    1,0,0,0,0, 0,0,5,0);
        add(0,0,0,5,    1,0,0,0,0, 0,0,5,0);
        add(1,0,0,1,    1,0,0,0,0, 0,0,5,0);
        add(1,0,0,1,    0,0,0,1,1, 0,0,5,0);

        @(posedge clk); #1;
        check_all("reset_state", 1,0,0,0,0, 0,0,0,1);
        do_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].en, (k == 0) ? tbl[i].ld : 1'b0, tbl[i].sel);
            check_all($sformatf("vec%0d", i), tbl[i].blank, tbl[i].hs, tbl[i].vs, tbl[i].fs,
                      tbl[i].run, tbl[i].x, tbl[i].y, tbl[i].idx, tbl[i].chk_idx);
        end

        // load one cycle before a frame start applies there; a load on the frame start waits a frame
        do_reset();
        step(1,0,0);
        for (int i = 1; i <= 134; i++) step(1,0,0);
        step(1,1,2);
        step(1,1,3);
        check_val("ld_early_fs", int'(o_frame_start), 1);
        check_val("ld_early_idx", int'(o_pattern_idx), 2);
        for (int i = 137; i <= 270; i++) step(1,0,0);
        step(1,0,0);
        check_val("ld_late_fs", int'(o_frame_start), 1);
        check_val("ld_late_idx", int'(o_pattern_idx), 3);

        // enable dropped mid-frame and restored: next frame follows with no gap
        do_reset();
        step(1,0,0);
        e = 0;
        for (int i = 0; i < 30; i++) begin step(1,0,0); e++; end
        for (int i = 0; i < 20; i++) begin step(0,0,0); e++; end
        check_val("stop_pend_running", int'(o_running), 1);
        got = 0;
        while (!got && e < 400) begin
            step(1,0,0); e++;
            if (o_frame_start) got = 1;
        end
        check_val("reenable_period", e, FT + 1);

        // asynchronous reset mid-line discards a pending load
        do_reset();
        step(1,0,0);
        for (int i = 0; i < 10; i++) step(1,0,0);
        step(1,1,6);
        for (int i = 12; i < 52; i++) step(1,0,0);
        check_all("pre_reset_pos", 0,0,0,0,1, 5,3,0,1);
        #2; rst_n = 1'b0; en = 1'b0;
        #1;
        check_all("async_reset", 1,0,0,0,0, 0,0,0,1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1,0,0);
        step(1,0,0);
        check_all("restart_first", 0,0,0,1,1, 0,0,0,1);
        for (int i = 0; i < FT; i++) step(1,0,0);
        check_all("restart_second", 0,0,0,1,1, 0,0,0,1);

`ifdef RGB_PATTERN_AUTOCYCLE_EN
        do_reset();
        step(1,0,0);
        nf = 0; guard = 0;
        while (nf < 18 && guard < 18 * FT + 20) begin
            step(1,0,0); guard++;
            if (o_frame_start) begin
                check_val($sformatf("auto_f%0d", nf), int'(o_pattern_idx), (nf / 2) % 8);
                nf++;
            end
        end
        check_val("auto_frames", nf, 18);

        exp_seq = '{0, 0, 4, 4, 5, 5};
        do_reset();
        step(1,0,0);
        nf = 0; guard = 0;
        while (nf < 6 && guard < 6 * FT + 20) begin
            step(1, (nf == 2 && guard == FT + 5), 4); guard++;
            if (o_frame_start) begin
                check_val($sformatf("auto_ld_f%0d", nf), int'(o_pattern_idx), exp_seq[nf]);
                nf++;
            end
        end
        check_val("auto_ld_frames", nf, 6);
`endif

        // randomized run against the reference model
        do_reset();
        model_reset();
        ren = 1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) ren = !ren;
            rld = ($urandom_range(0, 29) == 0);
            rsel = int'($urandom_range(0, 7));
            model_step(ren, rld, rsel);
            step(ren, rld, rsel);
            check_all($sformatf("rand%0d", i), e_blank, e_hs, e_vs, e_fs, e_run,
                      e_x, e_y, e_idx, e_run);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
